// File: rtl/gardner_ted_param_pkg.sv
// Shared constants and types for the Gardner timing-error detector.
// Holds the default widths, the phase-adjust direction encoding and the counter-width helper.
package gardner_ted_param_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int SPS_DEF      = 2;
  localparam int ER_W_DEF     = 2 * WIDTH_DEF + 2;
  localparam int AVG_LOG2_DEF = 3;

  typedef enum logic {
    ADJ_STUFF = 1'b0,
    ADJ_SKIP  = 1'b1
  } adj_dir_e;

  // Phase counter width: clog2(SPS), never narrower than one bit.
  function automatic int cnt_width(input int sps);
    int w;
    w = $clog2(sps);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/gardner_ted_param_if.sv
// Sample/adjust/error bundle between the ADC front end, the timing loop and the TED.
interface gardner_ted_param_if
  import gardner_ted_param_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ER_W  = 2 * WIDTH + 2
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] I_adc;
  logic signed [WIDTH-1:0] Q_adc;
  logic                    adj_valid;
  logic                    adj_dir;
  logic signed [ER_W-1:0]  er;
  logic                    ted_out_en;

  modport master (
    output in_valid, I_adc, Q_adc, adj_valid, adj_dir,
    input  er, ted_out_en
  );

  modport slave (
    input  in_valid, I_adc, Q_adc, adj_valid, adj_dir,
    output er, ted_out_en
  );
endinterface

// File: rtl/gardner_ted_param_mac.sv
// Three-stage Gardner datapath: S1 differences, S2 products, S3 I+Q sum.
// A valid shift register tracks each launched symbol; the sum holds between strobes.
module gardner_ted_mac #(
  parameter int WIDTH = 16,
  parameter int ER_W  = 2 * WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] i_prev,
  input  logic signed [WIDTH-1:0] i_cur,
  input  logic signed [WIDTH-1:0] i_mid,
  input  logic signed [WIDTH-1:0] q_prev,
  input  logic signed [WIDTH-1:0] q_cur,
  input  logic signed [WIDTH-1:0] q_mid,
  output logic                    out_valid,
  output logic signed [ER_W-1:0]  sum
);
  localparam int DW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 1;

  logic [2:0]              vld_r;
  logic signed [DW-1:0]    di_r, dq_r;
  logic signed [WIDTH-1:0] im_r, qm_r;
  logic signed [PW-1:0]    pi_r, pq_r;
  logic signed [ER_W-1:0]  sum_r;
  logic signed [PW-1:0]    im_x_s, qm_x_s, di_x_s, dq_x_s;

  // Sign-extend multiplier operands to the full product width.
  always_comb begin
    im_x_s = PW'(im_r);
    qm_x_s = PW'(qm_r);
    di_x_s = PW'(di_r);
    dq_x_s = PW'(dq_r);
  end

  // Pipeline registers; only the final sum is gated so er holds between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_r <= 3'b000;
      di_r  <= '0;
      dq_r  <= '0;
      im_r  <= '0;
      qm_r  <= '0;
      pi_r  <= '0;
      pq_r  <= '0;
      sum_r <= '0;
    end else begin
      vld_r <= {vld_r[1:0], in_valid};
      di_r  <= DW'(i_prev) - DW'(i_cur);
      dq_r  <= DW'(q_prev) - DW'(q_cur);
      im_r  <= i_mid;
      qm_r  <= q_mid;
      pi_r  <= im_x_s * di_x_s;
      pq_r  <= qm_x_s * dq_x_s;
      if (vld_r[1]) begin
        sum_r <= ER_W'(pi_r) + ER_W'(pq_r);
      end
    end
  end

  assign out_valid = vld_r[2];
  assign sum       = sum_r;

endmodule

// File: rtl/gardner_ted_param.sv
// Gardner TED top: symbol-phase counter, on-time/mid capture, skip/stuff handling.
// Define GARDNER_AVG_EN to average 2^AVG_LOG2 errors per output strobe.
module gardner_ted_param
  import gardner_ted_param_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int SPS      = SPS_DEF,
  parameter int ER_W     = 2 * WIDTH + 2
`ifdef GARDNER_AVG_EN
  ,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  gardner_ted_param_if.slave   bus
);
  localparam int               CNT_W    = cnt_width(SPS);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(SPS / 2);
  localparam logic [CNT_W:0]   SPS_X    = (CNT_W + 1)'(SPS);
  localparam logic [CNT_W:0]   STEP_ONE = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0]   STEP_TWO = (CNT_W + 1)'(2);

  logic [CNT_W-1:0]        count_r, count_next_s;
  logic [CNT_W:0]          count_sum_s;
  logic                    adj_pend_r, adj_act_s;
  adj_dir_e                adj_dir_r, adj_dir_s;
  logic                    stuff_s, take_s, on_time_s, mid_s;
  logic                    warm_r, go_r;
  logic signed [WIDTH-1:0] i_prev_r, i_cur_r, i_mid_r;
  logic signed [WIDTH-1:0] q_prev_r, q_cur_r, q_mid_r;
  logic                    mac_vld_s;
  logic signed [ER_W-1:0]  mac_sum_s;

  // A same-cycle request wins over a pending one; stuff discards the sample outright.
  always_comb begin
    adj_act_s = bus.adj_valid | adj_pend_r;
    if (bus.adj_valid) begin
      adj_dir_s = adj_dir_e'(bus.adj_dir);
    end else begin
      adj_dir_s = adj_dir_r;
    end
    stuff_s = bus.in_valid & adj_act_s & (adj_dir_s == ADJ_STUFF);
    take_s  = bus.in_valid & ~stuff_s;
    if (adj_act_s && (adj_dir_s == ADJ_SKIP)) begin
      count_sum_s = {1'b0, count_r} + STEP_TWO;
    end else begin
      count_sum_s = {1'b0, count_r} + STEP_ONE;
    end
    if (count_sum_s >= SPS_X) begin
      count_next_s = CNT_W'(count_sum_s - SPS_X);
    end else begin
      count_next_s = count_sum_s[CNT_W-1:0];
    end
    on_time_s = take_s & (count_r == '0);
    mid_s     = take_s & (count_r == MID_CNT);
  end

  // Phase counter, pending adjust, sample capture and pipeline launch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r    <= '0;
      adj_pend_r <= 1'b0;
      adj_dir_r  <= ADJ_STUFF;
      warm_r     <= 1'b0;
      go_r       <= 1'b0;
      i_prev_r   <= '0;
      i_cur_r    <= '0;
      i_mid_r    <= '0;
      q_prev_r   <= '0;
      q_cur_r    <= '0;
      q_mid_r    <= '0;
    end else begin
      if (bus.in_valid) begin
        adj_pend_r <= 1'b0;
        if (!stuff_s) begin
          count_r <= count_next_s;
        end
      end else if (bus.adj_valid) begin
        adj_pend_r <= 1'b1;
        adj_dir_r  <= adj_dir_e'(bus.adj_dir);
      end
      if (mid_s) begin
        i_mid_r <= bus.I_adc;
        q_mid_r <= bus.Q_adc;
      end
      go_r <= on_time_s & warm_r;
      if (on_time_s) begin
        i_prev_r <= i_cur_r;
        q_prev_r <= q_cur_r;
        i_cur_r  <= bus.I_adc;
        q_cur_r  <= bus.Q_adc;
        warm_r   <= 1'b1;
      end
    end
  end

  gardner_ted_mac #(
    .WIDTH (WIDTH),
    .ER_W  (ER_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (go_r),
    .i_prev    (i_prev_r),
    .i_cur     (i_cur_r),
    .i_mid     (i_mid_r),
    .q_prev    (q_prev_r),
    .q_cur     (q_cur_r),
    .q_mid     (q_mid_r),
    .out_valid (mac_vld_s),
    .sum       (mac_sum_s)
  );

`ifdef GARDNER_AVG_EN
  localparam int             ACC_W  = ER_W + AVG_LOG2;
  localparam int             N_W    = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;
  localparam logic [N_W-1:0] N_LAST = N_W'((1 << AVG_LOG2) - 1);

  logic signed [ACC_W-1:0] acc_r, acc_sum_s;
  logic [N_W-1:0]          n_r;
  logic signed [ER_W-1:0]  er_r;
  logic                    en_r;

  // Running sum including the error arriving this cycle.
  always_comb begin
    acc_sum_s = acc_r + ACC_W'(mac_sum_s);
  end

  // Averager: the arithmetic shift rounds toward -inf.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= '0;
      n_r   <= '0;
      er_r  <= '0;
      en_r  <= 1'b0;
    end else begin
      en_r <= 1'b0;
      if (mac_vld_s) begin
        if (n_r == N_LAST) begin
          er_r  <= ER_W'(acc_sum_s >>> AVG_LOG2);
          en_r  <= 1'b1;
          acc_r <= '0;
          n_r   <= '0;
        end else begin
          acc_r <= acc_sum_s;
          n_r   <= n_r + N_W'(1);
        end
      end
    end
  end

  assign bus.er         = er_r;
  assign bus.ted_out_en = en_r;
`else
  assign bus.er         = mac_sum_s;
  assign bus.ted_out_en = mac_vld_s;
`endif

endmodule

// File: tb/tb_gardner_ted_param.sv
// Directed bench for gardner_ted_param (SPS=2): expected errors go into a scoreboard
// queue with their due cycle when the on-time sample is driven, and are checked at strobe.
module tb_gardner_ted_param;
  import gardner_ted_param_pkg::*;

  localparam int WIDTH = WIDTH_DEF;
  localparam int SPS   = SPS_DEF;
  localparam int ER_W  = ER_W_DEF;
`ifdef GARDNER_AVG_EN
  localparam int AVG_LOG2 = AVG_LOG2_DEF;
  localparam int LAT      = 5;
`else
  localparam int LAT      = 4;
`endif

  typedef struct {
    logic signed [ER_W-1:0] val;
    int                     due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gardner_ted_param_if #(.WIDTH(WIDTH), .ER_W(ER_W)) bus ();

  gardner_ted_param #(
    .WIDTH (WIDTH),
    .SPS   (SPS),
    .ER_W  (ER_W)
`ifdef GARDNER_AVG_EN
    ,
    .AVG_LOG2 (AVG_LOG2)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t                   exp_q[$];
  int                     cyc       = 0;
  int                     last_k    = 0;
  int                     total_cnt = 0;
  int                     pass_cnt  = 0;
  logic signed [ER_W-1:0] last_val  = '0;
`ifdef GARDNER_AVG_EN
  logic signed [ER_W+AVG_LOG2-1:0] m_acc = '0;
  int                              m_n   = 0;
`endif

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
  endtask

  task automatic monitor();
    logic exp_en;
    exp_en = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("ted_out_en", 64'(bus.ted_out_en), 64'(exp_en));
    if (exp_en) begin
      check("er", 64'(bus.er), 64'(exp_q[0].val));
      last_val = exp_q[0].val;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic advance();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic drive(input logic v, input int i, input int q,
                       input logic av = 1'b0, input logic ad = 1'b0);
    bus.in_valid  = v;
    bus.I_adc     = WIDTH'(i);
    bus.Q_adc     = WIDTH'(q);
    bus.adj_valid = av;
    bus.adj_dir   = ad;
    last_k        = cyc;
    advance();
  endtask

  task automatic expect_err(input logic signed [ER_W-1:0] val);
    exp_t e;
`ifdef GARDNER_AVG_EN
    m_acc = m_acc + (ER_W + AVG_LOG2)'(val);
    m_n++;
    if (m_n == (1 << AVG_LOG2)) begin
      e.val = ER_W'(m_acc >>> AVG_LOG2);
      e.due = last_k + LAT;
      exp_q.push_back(e);
      m_acc = '0;
      m_n   = 0;
    end
`else
    e.val = val;
    e.due = last_k + LAT;
    exp_q.push_back(e);
`endif
  endtask

  task automatic model_reset();
    last_val = '0;
`ifdef GARDNER_AVG_EN
    m_acc = '0;
    m_n   = 0;
`endif
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 0, 0);
    // Held in reset with random activity: outputs stay zero.
    for (int n = 0; n < 8; n++) begin
      bus.in_valid  = 1'($urandom);
      bus.I_adc     = WIDTH'($urandom);
      bus.Q_adc     = WIDTH'($urandom);
      bus.adj_valid = 1'($urandom);
      bus.adj_dir   = 1'($urandom);
      advance();
      check("reset_er", 64'(bus.er), 64'sd0);
      check("reset_en", 64'(bus.ted_out_en), 64'sd0);
    end
    bus.adj_valid = 1'b0;
    reset = 1'b1;

    // Zero input: first on-time primes, then zero errors.
    drive(1'b1, 0, 0);
    drive(1'b1, 0, 0);
    drive(1'b1, 0, 0);  expect_err(0);
    drive(1'b1, 0, 0);
    drive(1'b1, 0, 0);  expect_err(0);

    // I only: mid 100 between 1000 and -1000.
    drive(1'b1, 0, 0);
    drive(1'b1, 1000, 0);   expect_err(0);
    drive(1'b1, 100, 0);
    drive(1'b1, -1000, 0);  expect_err(200000);

    // I and Q.
    drive(1'b1, 0, 0);
    drive(1'b1, 1000, -1000);  expect_err(0);
    drive(1'b1, 200, -300);
    drive(1'b1, -1000, 1000);  expect_err(1000000);

    // Same symbols with idle cycles carrying junk data.
    drive(1'b1, 0, 0);
    drive(1'b0, 1234, -1234);
    drive(1'b1, 1000, -1000);  expect_err(0);
    drive(1'b0, 1234, -1234);
    drive(1'b1, 200, -300);
    drive(1'b0, 1234, -1234);
    drive(1'b1, -1000, 1000);  expect_err(1000000);

    // Pending stuff: the 5555 sample is discarded.
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    drive(1'b1, 5555, 5555);
    drive(1'b1, 10, 0);
    drive(1'b1, 500, 0);   expect_err(-15000);

    // Stuff requested in the same cycle as the sample.
    drive(1'b1, 7777, 0, 1'b1, 1'b0);
    drive(1'b1, 3, 0);
    drive(1'b1, 100, 0);   expect_err(1200);

    // Skip at count SPS-1: the would-be on-time 9 becomes a mid sample.
    drive(1'b1, 4, 0, 1'b1, 1'b1);
    drive(1'b1, 9, 0);
    drive(1'b1, 50, 0);    expect_err(450);

    // Back-to-back stuff then skip: only skip applies, at count 0.
    drive(1'b1, 5, 0);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    drive(1'b1, 300, 0);   expect_err(-1250);
    drive(1'b1, 400, 0);   expect_err(-500);

    // Reset while the 1000 on-time sample is in the pipeline.
    drive(1'b1, 7, 0);
    drive(1'b1, 1000, 0);
    drive(1'b0, 0, 0);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      advance();
      check("midrst_er", 64'(bus.er), 64'sd0);
    end
    reset = 1'b1;
    drive(1'b1, 1000, 0);
    drive(1'b1, 100, 0);
    drive(1'b1, -1000, 0);  expect_err(200000);

    for (int n = 0; n < 10; n++) begin
      drive(1'b0, 0, 0);
    end
    check("er_hold", 64'(bus.er), 64'(last_val));
    check("queue_drained", 64'(exp_q.size()), 64'sd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
